mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle controller that sequences the datapath's H6 shift-add multiplier to execute one register-register multiply (Rd:Rd+1 ← Rd × Rs, unsigned 16×16→32). It sits between the instruction decoder and the datapath top, drives the register A/S-bus selects, B0, shifter pass-through, H6 step strobes and the PSW update, and owns the A, B and S buses for the whole operation. A new request is accepted only when idle.

## Interface
- W, default 16: operand width; also the iteration count.
- CNT_W, default 5: width of the iteration counter; must hold W.
- CLK  in  1  system clock; all state changes on the rising edge.
- CLR  in  1  asynchronous, active-low reset.
- start  in  1  request strobe, sampled in IDLE only.
- rd  in  3  destination/multiplicand register index; high word → Rd, low word → R((rd+1) mod 8).
- rs  in  3  multiplier register index.
- abort  in  1  synchronous cancel.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle reject pulse.
- RA  out  8  one-hot A-bus selects R0A..R7A.
- SR  out  8  one-hot S-bus write enables SR0..SR7.
- SB0, B0B, SHS  out  1 each  B0 load, B0 → B bus, shifter → S bus. Shifter function inputs are held 0, which is pass-through.
- MUL1, MUL2_1, MUL2_2  out  1 each  H6 input selects.
- Rst_H6, inQLK, inTWO, inTHREE, inFOUR  out  1 each  H6 step strobes.
- ALS_H6_a, ALS_H6_q  out  1 each  H6 A/Q registers → S bus.
- MUL3, EX0  out  1 each  PSW source select and flag-update enable.

## Operation
- States: IDLE, LDB, CLRM, LDQ, ADD, SHF, FIN, WRH, WRL, DONE.
- IDLE: on start=1, latch rd/rs.
  - If rd ∈ {4,5}, assert err for 1 cycle, stay in IDLE and drive no datapath signal. R5 is the PSW and is not S-bus writable.
  - Otherwise go to LDB.
- LDB: RA[rs], SHS, SB0 — Rs → B0.
- CLRM: Rst_H6 — clears H6 A/Q.
- LDQ: RA[rd], B0B, MUL1, inQLK — loads Rd into Q.
- ADD: B0B, MUL2_1, inTWO — conditional add of B into A when Q[0]=1.
- SHF: inTHREE — shifts A:Q right one bit; increments the counter.
- ADD/SHF loop:
  - The counter is cleared in LDQ.
  - SHF → ADD while counter < W−1.
  - SHF → FIN when the counter equals W−1, i.e. after exactly W iterations.
- FIN: inFOUR, MUL3, EX0 — latches the final product and updates PSW N/Z/V/C from the H6 outputs.
- WRH: ALS_H6_a, SR[rd] — high word → Rd.
- WRL: ALS_H6_q, SR[(rd+1) mod 8] — low word; index 7 wraps to 0.
- DONE: done=1 → IDLE.
- All control outputs are a Moore decode of a registered state. In any cycle at most one S-bus source and at most one A-bus select is active; SR has at most one bit set.
- MUL2_2 and unlisted outputs are 0 in every state.
- busy = 1 in every state except IDLE.
- start while busy is ignored; it is not queued.
- abort = 1 in LDB..FIN: next state is IDLE with all outputs 0. No register or PSW write occurs, and done and err stay 0.
- abort in WRH, WRL or DONE is ignored; the write-back completes atomically.
- Reset (CLR=0) at any time: state IDLE, counter 0, latched indices 0, and every output 0 immediately (asynchronous). An in-flight operation is discarded.

## Timing
- Cycle 0 = edge sampling start. Schedule:
  - cycle 1 LDB, 2 CLRM, 3 LDQ
  - cycles 4–35 ADD/SHF alternating, W iterations
  - 36 FIN, 37 WRH, 38 WRL, 39 DONE
- First cycle with busy=1 is cycle 1; done=1 in cycle 39; IDLE again at cycle 40.
- Latency from start to done is 2W+7 = 39 cycles.
- Back-to-back: start sampled in cycle 40 is accepted; start in cycle 39 (DONE) is ignored.
- err asserts in cycle 1 with busy=0.

## Test plan
- R1=0x0003, R2=0x0005, start rd=2 rs=1 → R2=0x0000, R3=0x000F; done exactly at cycle 39; PSW Z=0, N=0.
- R6=0xFFFF, R7=0xFFFF, rd=7 rs=6 → R7=0xFFFE, R0=0x0001 (index wrap); no SR bit other than SR7 or SR0 ever set.
- rd=4 or rd=5 → err pulse in cycle 1, busy stays 0, all RA/SR/H6 strobes stay 0.
- abort in cycle 20 (ADD/SHF loop) → IDLE at cycle 21, no SR pulse, registers unchanged; abort in cycle 37 → write-back completes, done in cycle 39.
- CLR low in cycle 10 → all outputs 0 immediately; after release a fresh start completes in 39 cycles; a start issued while busy has no effect.
- Every cycle of every run: one-hot checks on RA, on SR, and on the S-bus sources {SHS, ALS_H6_a, ALS_H6_q}.

Source files
------------

// File: rtl/mul_sequencer.sv
// mul_sequencer
// Multi-cycle controller that sequences the H6 shift-add multiplier to run one
// unsigned register-register multiply: Rd:Rd+1 <- Rd * Rs (W x W -> 2W).
// While busy it owns the A, B and S buses of the datapath.
//
// Ports
//   CLK                 system clock, rising edge
//   CLR                 asynchronous active-low reset
//   start, rd, rs       request strobe and register indices (sampled in IDLE)
//   abort               synchronous cancel, honoured in LDB..FIN only
//   busy, done, err     status: in progress, completion pulse, reject pulse
//   RA, SR              one-hot A-bus selects / S-bus write enables
//   SB0, B0B, SHS       B0 load, B0 -> B bus, shifter -> S bus
//   MUL1, MUL2_1, MUL2_2            H6 input selects
//   Rst_H6, inQLK, inTWO, inTHREE, inFOUR   H6 step strobes
//   ALS_H6_a, ALS_H6_q  H6 A/Q registers -> S bus
//   MUL3, EX0           PSW source select and flag-update enable
module mul_sequencer #(
  parameter int W     = 16,
  parameter int CNT_W = 5
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       start,
  input  logic [2:0] rd,
  input  logic [2:0] rs,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] RA,
  output logic [7:0] SR,
  output logic       SB0,
  output logic       B0B,
  output logic       SHS,
  output logic       MUL1,
  output logic       MUL2_1,
  output logic       MUL2_2,
  output logic       Rst_H6,
  output logic       inQLK,
  output logic       inTWO,
  output logic       inTHREE,
  output logic       inFOUR,
  output logic       ALS_H6_a,
  output logic       ALS_H6_q,
  output logic       MUL3,
  output logic       EX0
);

  typedef enum logic [3:0] {
    S_IDLE, S_LDB, S_CLRM, S_LDQ, S_ADD, S_SHF, S_FIN, S_WRH, S_WRL, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       rd_q, rd_nxt;
  logic [2:0]       rs_q, rs_nxt;
  logic             err_q, err_nxt;
  logic [2:0]       rd_lo;

  // R4 is excluded because its pair partner R5 is the PSW, which is not
  // S-bus writable; R5 itself is excluded for the same reason.
  logic reject;
  assign reject = (rd == 3'd4) || (rd == 3'd5);

  // Low word goes to the next register; 3-bit arithmetic wraps R7 -> R0.
  assign rd_lo = rd_q + 3'd1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= S_IDLE;
      cnt   <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rd_q  <= rd_nxt;
      rs_q  <= rs_nxt;
      err_q <= err_nxt;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = rd_q;
    rs_nxt    = rs_q;
    err_nxt   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (reject) begin
            err_nxt = 1'b1;
          end else begin
            rd_nxt    = rd;
            rs_nxt    = rs;
            state_nxt = S_LDB;
          end
        end
      end
      S_LDB:  state_nxt = abort ? S_IDLE : S_CLRM;
      S_CLRM: state_nxt = abort ? S_IDLE : S_LDQ;
      S_LDQ: begin
        cnt_nxt   = '0;
        state_nxt = abort ? S_IDLE : S_ADD;
      end
      S_ADD:  state_nxt = abort ? S_IDLE : S_SHF;
      S_SHF: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (abort)                  state_nxt = S_IDLE;
        else if (cnt == LAST_ITER)  state_nxt = S_FIN;
        else                        state_nxt = S_ADD;
      end
      S_FIN:  state_nxt = abort ? S_IDLE : S_WRH;
      // Write-back is atomic: abort is no longer looked at from here on.
      S_WRH:  state_nxt = S_WRL;
      S_WRL:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode: outputs depend only on registered state, so reset
  // forces them all to 0 at once.
  always_comb begin
    busy     = (state != S_IDLE);
    done     = 1'b0;
    err      = err_q;
    RA       = '0;
    SR       = '0;
    SB0      = 1'b0;
    B0B      = 1'b0;
    SHS      = 1'b0;
    MUL1     = 1'b0;
    MUL2_1   = 1'b0;
    MUL2_2   = 1'b0;
    Rst_H6   = 1'b0;
    inQLK    = 1'b0;
    inTWO    = 1'b0;
    inTHREE  = 1'b0;
    inFOUR   = 1'b0;
    ALS_H6_a = 1'b0;
    ALS_H6_q = 1'b0;
    MUL3     = 1'b0;
    EX0      = 1'b0;

    unique case (state)
      S_IDLE: ;
      S_LDB: begin
        RA  = 8'd1 << rs_q;
        SHS = 1'b1;
        SB0 = 1'b1;
      end
      S_CLRM: Rst_H6 = 1'b1;
      S_LDQ: begin
        RA    = 8'd1 << rd_q;
        B0B   = 1'b1;
        MUL1  = 1'b1;
        inQLK = 1'b1;
      end
      S_ADD: begin
        B0B    = 1'b1;
        MUL2_1 = 1'b1;
        inTWO  = 1'b1;
      end
      S_SHF: inTHREE = 1'b1;
      S_FIN: begin
        inFOUR = 1'b1;
        MUL3   = 1'b1;
        EX0    = 1'b1;
      end
      S_WRH: begin
        ALS_H6_a = 1'b1;
        SR       = 8'd1 << rd_q;
      end
      S_WRL: begin
        ALS_H6_q = 1'b1;
        SR       = 8'd1 << rd_lo;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer
// Self-checking bench for mul_sequencer. A small behavioural model of the
// register file, B0, H6 multiplier and PSW reacts to the controller strobes,
// so products and write-back targets are observed as real register values.
module tb_mul_sequencer;

  localparam int W = 16;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       start = 1'b0;
  logic [2:0] rd = '0;
  logic [2:0] rs = '0;
  logic       abort = 1'b0;
  logic       busy, done, err;
  logic [7:0] RA, SR;
  logic       SB0, B0B, SHS, MUL1, MUL2_1, MUL2_2;
  logic       Rst_H6, inQLK, inTWO, inTHREE, inFOUR;
  logic       ALS_H6_a, ALS_H6_q, MUL3, EX0;

  always #5 CLK = ~CLK;

  mul_sequencer #(.W(W), .CNT_W(5)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .rd(rd), .rs(rs), .abort(abort),
    .busy(busy), .done(done), .err(err), .RA(RA), .SR(SR),
    .SB0(SB0), .B0B(B0B), .SHS(SHS), .MUL1(MUL1), .MUL2_1(MUL2_1),
    .MUL2_2(MUL2_2), .Rst_H6(Rst_H6), .inQLK(inQLK), .inTWO(inTWO),
    .inTHREE(inTHREE), .inFOUR(inFOUR), .ALS_H6_a(ALS_H6_a),
    .ALS_H6_q(ALS_H6_q), .MUL3(MUL3), .EX0(EX0)
  );

  logic [30:0] ctrl;
  assign ctrl = {RA, SR, SB0, B0B, SHS, MUL1, MUL2_1, MUL2_2, Rst_H6, inQLK,
                 inTWO, inTHREE, inFOUR, ALS_H6_a, ALS_H6_q, MUL3, EX0};

  // ---------------- datapath model ----------------
  logic [15:0] regs [8];
  logic [15:0] b0, h_a, h_q;
  logic        h_c;
  logic        psw_n, psw_z;
  logic        tb_wr = 1'b0;
  logic [2:0]  tb_idx = '0;
  logic [15:0] tb_val = '0;

  function automatic logic [2:0] oh_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(posedge CLK) begin
    if (tb_wr) regs[tb_idx] <= tb_val;
    else if (|SR) regs[oh_idx(SR)] <= ALS_H6_a ? h_a : h_q;
    if (SB0 && SHS) b0 <= regs[oh_idx(RA)];
    if (Rst_H6) begin
      h_a <= '0; h_q <= '0; h_c <= 1'b0;
    end else if (MUL1 && inQLK) begin
      h_q <= regs[oh_idx(RA)];
    end else if (MUL2_1 && inTWO && B0B && h_q[0]) begin
      {h_c, h_a} <= {1'b0, h_a} + {1'b0, b0};
    end else if (inTHREE) begin
      {h_a, h_q} <= {h_c, h_a, h_q[15:1]};
      h_c <= 1'b0;
    end
    if (EX0 && MUL3 && inFOUR) begin
      psw_n <= h_a[15];
      psw_z <= ({h_a, h_q} == 32'd0);
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int         done_at, err_at, err_cnt, first_busy, last_busy;
  logic [7:0] sr_seen;
  logic [30:0] ctrl_seen;

  task automatic load(input logic [2:0] idx, input logic [15:0] val);
    tb_wr = 1'b1; tb_idx = idx; tb_val = val;
    @(posedge CLK); #1;
    tb_wr = 1'b0;
  endtask

  task automatic preload(input logic [2:0] r_d, input logic [15:0] v_d,
                         input logic [2:0] r_s, input logic [15:0] v_s);
    for (int i = 0; i < 8; i++) load(3'(i), 16'h5A00 | 16'(i));
    load(r_s, v_s);
    load(r_d, v_d);
  endtask

  // Per-cycle observation: bus exclusivity checks plus event bookkeeping.
  task automatic sample_cycle(input int c);
    check("ra_onehot0", 64'($onehot0(RA)), 64'd1);
    check("sr_onehot0", 64'($onehot0(SR)), 64'd1);
    check("sbus_src_onehot0", 64'($onehot0({SHS, ALS_H6_a, ALS_H6_q})), 64'd1);
    check("mul2_2_zero", 64'(MUL2_2), 64'd0);
    if (err) begin
      err_cnt++;
      if (err_at < 0) err_at = c;
      check("err_while_not_busy", 64'(busy), 64'd0);
    end
    if (done && done_at < 0) done_at = c;
    if (busy) begin
      if (first_busy < 0) first_busy = c;
      last_busy = c;
    end
    sr_seen   = sr_seen | SR;
    ctrl_seen = ctrl_seen | ctrl;
  endtask

  // Cycle 0 is the edge that samples start. abort/restart/clr are applied
  // during the named cycle (negative means never).
  task automatic run_op(input logic [2:0] r_d, input logic [2:0] r_s, input int ncyc,
                        input int abort_at, input int restart_at, input int clr_at);
    done_at = -1; err_at = -1; err_cnt = 0; first_busy = -1; last_busy = -1;
    sr_seen = '0; ctrl_seen = '0;
    rd = r_d; rs = r_s; start = 1'b1; abort = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      sample_cycle(c);
      if (c == clr_at) begin
        CLR = 1'b0;
        #1;
        check("clr_async_outputs_zero", 64'({busy, done, err, ctrl}), 64'd0);
      end else if (c == clr_at + 1) begin
        CLR = 1'b1;
      end
      start = (c == restart_at);
      abort = (c == abort_at);
      @(posedge CLK); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] vd;
    logic [15:0] vs;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        rej;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{3'd2, 3'd1, 16'h0005, 16'h0003, 16'h0000, 16'h000F, 1'b0};
    vecs[1] = '{3'd7, 3'd6, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
    vecs[2] = '{3'd0, 3'd3, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{3'd1, 3'd1, 16'h0100, 16'h0100, 16'h0001, 16'h0000, 1'b0};
    vecs[4] = '{3'd3, 3'd0, 16'h8000, 16'h0003, 16'h0001, 16'h8000, 1'b0};
    vecs[5] = '{3'd6, 3'd2, 16'hABCD, 16'h0001, 16'h0000, 16'hABCD, 1'b0};
    vecs[6] = '{3'd4, 3'd1, 16'h0002, 16'h0003, 16'h0000, 16'h0000, 1'b1};
    vecs[7] = '{3'd5, 3'd2, 16'h0002, 16'h0003, 16'h0000, 16'h0000, 1'b1};

    // Reset state: outputs forced to 0 while CLR is low.
    #12;
    check("reset_outputs_zero", 64'({busy, done, err, ctrl}), 64'd0);
    @(posedge CLK); #1;
    CLR = 1'b1;
    @(posedge CLK); #1;
    check("idle_after_reset_busy", 64'(busy), 64'd0);

    // Table-driven operations.
    foreach (vecs[k]) begin
      vec_t       v;
      logic [2:0] lo_idx;
      v = vecs[k];
      lo_idx = v.rd + 3'd1;
      preload(v.rd, v.vd, v.rs, v.vs);
      if (v.rej) begin
        run_op(v.rd, v.rs, 5, -1, -1, -1);
        check($sformatf("v%0d_err_cycle", k), 64'(err_at), 64'd1);
        check($sformatf("v%0d_err_width", k), 64'(err_cnt), 64'd1);
        check($sformatf("v%0d_never_busy", k), 64'(first_busy), 64'(-1));
        check($sformatf("v%0d_no_datapath", k), 64'(ctrl_seen), 64'd0);
        check($sformatf("v%0d_rd_unchanged", k), 64'(regs[v.rd]), 64'(v.vd));
      end else begin
        run_op(v.rd, v.rs, 42, -1, -1, -1);
        check($sformatf("v%0d_first_busy", k), 64'(first_busy), 64'd1);
        check($sformatf("v%0d_done_cycle", k), 64'(done_at), 64'd39);
        check($sformatf("v%0d_last_busy", k), 64'(last_busy), 64'd39);
        check($sformatf("v%0d_no_err", k), 64'(err_cnt), 64'd0);
        check($sformatf("v%0d_hi", k), 64'(regs[v.rd]), 64'(v.hi));
        check($sformatf("v%0d_lo", k), 64'(regs[lo_idx]), 64'(v.lo));
        check($sformatf("v%0d_sr_targets", k), 64'(sr_seen),
              64'((8'd1 << v.rd) | (8'd1 << lo_idx)));
        check($sformatf("v%0d_psw_z", k), 64'(psw_z), 64'({v.hi, v.lo} == 32'd0));
        check($sformatf("v%0d_psw_n", k), 64'(psw_n), 64'(v.hi[15]));
      end
    end

    // Abort inside the ADD/SHF loop: back to IDLE, no write-back.
    preload(3'd2, 16'h0005, 3'd1, 16'h0003);
    run_op(3'd2, 3'd1, 42, 20, -1, -1);
    check("abort20_last_busy", 64'(last_busy), 64'd20);
    check("abort20_no_done", 64'(done_at), 64'(-1));
    check("abort20_no_sr", 64'(sr_seen), 64'd0);
    check("abort20_r2", 64'(regs[2]), 64'h0005);
    check("abort20_r3", 64'(regs[3]), 64'h5A03);

    // Abort during WRH is ignored: write-back completes.
    run_op(3'd2, 3'd1, 42, 37, -1, -1);
    check("abort37_done_cycle", 64'(done_at), 64'd39);
    check("abort37_r2", 64'(regs[2]), 64'h0000);
    check("abort37_r3", 64'(regs[3]), 64'h000F);

    // Start while busy and start in DONE are both ignored.
    preload(3'd2, 16'h0005, 3'd1, 16'h0003);
    run_op(3'd2, 3'd1, 45, -1, 15, -1);
    check("restart15_done_cycle", 64'(done_at), 64'd39);
    check("restart15_last_busy", 64'(last_busy), 64'd39);
    preload(3'd2, 16'h0005, 3'd1, 16'h0003);
    run_op(3'd2, 3'd1, 45, -1, 39, -1);
    check("restart39_last_busy", 64'(last_busy), 64'd39);

    // Reset in cycle 10 discards the operation; a fresh start completes.
    preload(3'd2, 16'h0005, 3'd1, 16'h0003);
    run_op(3'd2, 3'd1, 14, -1, -1, 10);
    check("clr10_last_busy", 64'(last_busy), 64'd10);
    check("clr10_no_sr", 64'(sr_seen), 64'd0);
    check("clr10_r2_kept", 64'(regs[2]), 64'h0005);
    run_op(3'd2, 3'd1, 42, -1, -1, -1);
    check("post_clr_done_cycle", 64'(done_at), 64'd39);
    check("post_clr_r3", 64'(regs[3]), 64'h000F);

    // Back-to-back: start sampled in cycle 40 is accepted.
    preload(3'd2, 16'h0005, 3'd1, 16'h0003);
    run_op(3'd2, 3'd1, 45, -1, 40, -1);
    check("b2b_done_cycle", 64'(done_at), 64'd39);
    check("b2b_busy_again", 64'(last_busy), 64'd45);
    CLR = 1'b0;
    #1;
    check("final_clr_outputs_zero", 64'({busy, done, err, ctrl}), 64'd0);
    @(posedge CLK); #1;
    CLR = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
